// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-write FSM states, frame geometry and default timing.
// Used by both the host writer and the PS/2 receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_REQ     = 3'd2,
        S_TX      = 3'd3,
        S_ACK     = 3'd4,
        S_RELEASE = 3'd5
    } ps2_state_t;

    localparam int FRAME_BITS         = 10;
    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_TIMEOUT_CYCLES = 750000;

    // Frame is shifted out LSB-first: data[7:0], odd parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a PS/2 pad line with a one-cycle falling-edge strobe.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic fall
);

    logic meta;
    logic stable;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta   <= 1'b0;
            stable <= 1'b0;
        end else begin
            meta   <= line;
            stable <= meta;
        end
    end

    assign level = stable;
    assign fall  = stable & ~meta;

endmodule

// File: rtl/ps2_write_host.sv
// PS/2 host-to-device byte writer: inhibit, request-to-send, clocked-out frame,
// device ACK check and bus release, with a watchdog on every device-driven phase.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | lines released, waiting for wr_en
// INHIBIT   | kc held low for INHIBIT_CYCLES
// REQ       | kc and kd both low for one cycle (start bit)
// TX        | kc released; each device falling edge shifts the next bit
// ACK       | waiting for the 11th falling edge to sample the device ACK
// RELEASE   | waiting for both lines high before reporting the result
module ps2_write_host
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kc,
    input  logic       kd,
    output logic       kc_oe,
    output logic       kd_oe,
    input  logic       wr_en,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       tx_error
);

    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] INHIBIT_LOAD = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic kc_level, kc_fall;
    logic kd_level, kd_fall_unused;

    ps2_sync_edge u_kc_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (kc),
        .level (kc_level),
        .fall  (kc_fall)
    );

    // Only the level of kd matters to the writer; its edge strobe serves the receiver.
    ps2_sync_edge u_kd_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (kd),
        .level (kd_level),
        .fall  (kd_fall_unused)
    );

    ps2_state_t            state, state_nxt;
    logic [TW-1:0]         timer, timer_nxt;
    logic [3:0]            bit_cnt, bit_cnt_nxt;
    logic [FRAME_BITS-1:0] frame, frame_nxt;
    logic                  ack_ok, ack_ok_nxt;
    logic                  kc_oe_nxt, kd_oe_nxt, busy_nxt, done_nxt, tx_error_nxt;
    logic                  timer_tc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            frame    <= '0;
            ack_ok   <= 1'b0;
            kc_oe    <= 1'b0;
            kd_oe    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            bit_cnt  <= bit_cnt_nxt;
            frame    <= frame_nxt;
            ack_ok   <= ack_ok_nxt;
            kc_oe    <= kc_oe_nxt;
            kd_oe    <= kd_oe_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            tx_error <= tx_error_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        bit_cnt_nxt  = bit_cnt;
        frame_nxt    = frame;
        ack_ok_nxt   = ack_ok;
        kc_oe_nxt    = kc_oe;
        kd_oe_nxt    = kd_oe;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        tx_error_nxt = 1'b0;
        timer_tc     = (timer == '0);

        case (state)
            S_IDLE: begin
                if (wr_en) begin
                    state_nxt   = S_INHIBIT;
                    frame_nxt   = build_frame(din);
                    timer_nxt   = INHIBIT_LOAD;
                    bit_cnt_nxt = '0;
                    kc_oe_nxt   = 1'b1;
                    kd_oe_nxt   = 1'b0;
                    busy_nxt    = 1'b1;
                end
            end

            S_INHIBIT: begin
                if (timer_tc) begin
                    state_nxt = S_REQ;
                    kd_oe_nxt = 1'b1;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end

            S_REQ: begin
                state_nxt = S_TX;
                kc_oe_nxt = 1'b0;
                timer_nxt = TIMEOUT_LOAD;
            end

            S_TX: begin
                if (kc_fall) begin
                    timer_nxt   = TIMEOUT_LOAD;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    kd_oe_nxt   = ~frame[0];
                    frame_nxt   = {1'b0, frame[FRAME_BITS-1:1]};
                    if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                        state_nxt = S_ACK;
                    end
                end else if (timer_tc) begin
                    state_nxt    = S_IDLE;
                    kc_oe_nxt    = 1'b0;
                    kd_oe_nxt    = 1'b0;
                    busy_nxt     = 1'b0;
                    tx_error_nxt = 1'b1;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end

            S_ACK: begin
                if (kc_fall) begin
                    ack_ok_nxt = ~kd_level;
                    state_nxt  = S_RELEASE;
                    timer_nxt  = TIMEOUT_LOAD;
                end else if (timer_tc) begin
                    state_nxt    = S_IDLE;
                    kc_oe_nxt    = 1'b0;
                    kd_oe_nxt    = 1'b0;
                    busy_nxt     = 1'b0;
                    tx_error_nxt = 1'b1;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end

            S_RELEASE: begin
                if (kc_level && kd_level) begin
                    state_nxt    = S_IDLE;
                    busy_nxt     = 1'b0;
                    done_nxt     = ack_ok;
                    tx_error_nxt = ~ack_ok;
                end else if (kc_fall) begin
                    timer_nxt = TIMEOUT_LOAD;
                end else if (timer_tc) begin
                    state_nxt    = S_IDLE;
                    kc_oe_nxt    = 1'b0;
                    kd_oe_nxt    = 1'b0;
                    busy_nxt     = 1'b0;
                    tx_error_nxt = 1'b1;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                kc_oe_nxt = 1'b0;
                kd_oe_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_write_host.sv
// Directed bench for ps2_write_host with an open-drain PS/2 device model.
module tb_ps2_write_host;
    import ps2_pkg::*;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 300;
    localparam int HALF    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       kc, kd, kc_oe, kd_oe;
    logic       wr_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       busy, done, tx_error;
    logic       dev_kc_low = 1'b0;
    logic       dev_kd_low = 1'b0;

    assign kc = ~(kc_oe | dev_kc_low);
    assign kd = ~(kd_oe | dev_kd_low);

    always #5 clk = ~clk;

    ps2_write_host #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .kc       (kc),
        .kd       (kd),
        .kc_oe    (kc_oe),
        .kd_oe    (kd_oe),
        .wr_en    (wr_en),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .tx_error (tx_error)
    );

    int checks = 0;
    int fails  = 0;
    int done_seen = 0, err_seen = 0, overlap_bad = 0, busy_bad = 0;

    always @(negedge clk) begin
        if (done) done_seen++;
        if (tx_error) err_seen++;
        if (done && tx_error) overlap_bad++;
        if ((done || tx_error) && busy) busy_bad++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       ack;
        logic       inject;
        logic [9:0] exp_frame;
        logic       exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic run_xfer(input vec_t v);
        int n, d0, e0;
        logic [9:0] got;
        got = '0;
        d0 = done_seen;
        e0 = err_seen;
        @(negedge clk);
        din = v.d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        din = 8'h00;
        check("busy_after_accept", busy, 1);
        n = 0;
        while (!kd_oe && n < INHIBIT + 50) begin
            if (kc_oe) n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INHIBIT);
        check("req_kd_oe", kd_oe, 1);
        if (!kd_oe) return;
        @(negedge clk);
        check("tx_kc_released", kc_oe, 0);
        check("tx_start_bit", kd_oe, 1);
        for (int i = 0; i < 11; i++) begin
            if (i == 10 && v.ack) dev_kd_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_kc_low = 1'b1;
            if (v.inject && i == 4) begin
                wr_en = 1'b1;
                din = ~v.d;
                @(negedge clk);
                wr_en = 1'b0;
                din = 8'h00;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (i < 10) got[i] = kd;
            dev_kc_low = 1'b0;
        end
        dev_kd_low = 1'b0;
        n = 0;
        while (!(done || tx_error) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("result_pulse", done | tx_error, 1);
        check("busy_fall_with_pulse", busy, 0);
        check("frame_bits", got, v.exp_frame);
        repeat (3) @(negedge clk);
        check("done_count", done_seen - d0, v.exp_done ? 1 : 0);
        check("err_count", err_seen - e0, v.exp_done ? 0 : 1);
        check("lines_released", {kc_oe, kd_oe}, 0);
    endtask

    initial begin
        int n, d0, e0;
        vecs[0] = '{8'hED, 1'b1, 1'b0, 10'h3ED, 1'b1};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 10'h300, 1'b1};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 10'h201, 1'b1};
        vecs[3] = '{8'hA5, 1'b0, 1'b0, 10'h3A5, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 10'h3FF, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 10'h280, 1'b1};

        repeat (5) @(negedge clk);
        check("rst_kc_oe", kc_oe, 0);
        check("rst_kd_oe", kd_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_error", tx_error, 0);
        check("rst_state", 32'(dut.state), 32'(S_IDLE));
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

        // Device never clocks after the request.
        d0 = done_seen;
        e0 = err_seen;
        @(negedge clk);
        din = 8'h5A;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        n = 0;
        while (!(kd_oe && !kc_oe) && n < INHIBIT + 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!tx_error && n < TIMEOUT + 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TIMEOUT);
        check("timeout_lines", {kc_oe, kd_oe}, 0);
        check("timeout_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("timeout_err_count", err_seen - e0, 1);
        check("timeout_done_count", done_seen - d0, 0);

        // Reset in the middle of TX.
        d0 = done_seen;
        e0 = err_seen;
        @(negedge clk);
        din = 8'h3C;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        n = 0;
        while (!(kd_oe && !kc_oe) && n < INHIBIT + 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            repeat (HALF) @(negedge clk);
            dev_kc_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_kc_low = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        dev_kc_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_outputs", {kc_oe, kd_oe, busy, done, tx_error}, 0);
        check("midrst_state", 32'(dut.state), 32'(S_IDLE));
        dev_kc_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_done", done_seen - d0, 0);
        check("midrst_no_err", err_seen - e0, 0);
        check("midrst_idle_busy", busy, 0);

        run_xfer(vecs[0]);

        check("done_err_overlap", overlap_bad, 0);
        check("busy_during_pulse", busy_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ps2_write_host.md
PS2_WRITE_HOST -- requirements
Module: ps2_write_host

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clk cycles kc is held low before the request (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, maximum clk cycles to wait for any device clock edge or line release (15 ms at 50 MHz).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low.
REQ-005 kc  input  1  PS2 clock line as read from the pad.
REQ-006 kd  input  1  PS2 data line as read from the pad.
REQ-007 kc_oe  output  1  1 = pull PS2 clock low (open-drain); 0 = release.
REQ-008 kd_oe  output  1  1 = pull PS2 data low (open-drain); 0 = release.
REQ-009 wr_en  input  1  single-cycle request to send din.
REQ-010 din  input  8  byte to transmit to the device.
REQ-011 busy  output  1  high from the cycle after an accepted wr_en until done or error is asserted.
REQ-012 done  output  1  one-cycle pulse: byte sent and device ACK received.
REQ-013 tx_error  output  1  one-cycle pulse: no ACK, or timeout.

Function
REQ-014 kc and kd shall each pass through a 2-flop synchronizer. The kc falling-edge strobe kc_ne shall be high for one clk when the sync flops read 1 then 0.
REQ-015 wr_en shall be accepted only in IDLE. din shall be latched, together with odd parity (~^din), into a 10-bit frame {stop=1, parity, din[7:0]}. wr_en while busy shall be ignored.
REQ-016 States and transitions:
- IDLE: wait for wr_en.
- INHIBIT: kc_oe=1 for INHIBIT_CYCLES.
- REQ: kc_oe=1, kd_oe=1 (start bit) for 1 cycle, then release kc.
- TX: kd_oe held from the start bit until the first frame bit is shifted.
- ACK: wait for the device acknowledge.
- RELEASE: wait for kc=1 and kd=1.
- IDLE: return, pulsing done or tx_error.
REQ-017 In TX, each kc_ne shall shift the next frame bit LSB-first: kd_oe = ~bit. A 4-bit counter shall count 1..10; on the 10th kc_ne, kd_oe=0 (stop), then go to ACK.
REQ-018 In ACK, on the next kc_ne, synchronized kd=0 shall mean ACK OK and kd=1 shall mean ACK fail; then go to RELEASE.
REQ-019 In RELEASE, once both synchronized lines read 1: go to IDLE and pulse done (ACK OK) or tx_error (ACK fail).
REQ-020 A timeout counter shall reset on every kc_ne and on every state entry. Reaching TIMEOUT_CYCLES in TX, ACK or RELEASE shall set kc_oe=kd_oe=0, pulse tx_error and go to IDLE.
REQ-021 done and tx_error shall never be asserted in the same cycle. busy shall fall in the same cycle as either pulse.
REQ-022 kd_oe and kc_oe shall be registered outputs, glitch-free.

Reset
REQ-023 With rst=0 at a clk edge:
- state=IDLE; kc_oe=kd_oe=0; busy=done=tx_error=0.
- Counters, frame and sync flops cleared to 0.
- Any transfer in progress is aborted with no done or tx_error pulse.

Structure
REQ-024 Package ps2_pkg shall hold the state enum, the FRAME_BITS=10 constant and the default cycle constants, shared with the PS2 receiver.
REQ-025 Sub-module ps2_sync_edge (2-flop synchronizer plus falling-edge strobe) shall be instantiated once each for kc and kd, and is reusable by the receiver.

Verification
REQ-026 din=8'hED, device model clocks at 12.5 kHz and ACKs -> kd_oe bits LSB-first 1,0,1,1,0,1,1,1 (kd levels), parity level 1, stop released, done pulses once, busy falls.
REQ-027 din=8'h00 -> parity level 1, 8 low data bits; din=8'h01 -> parity level 0; both -> done.
REQ-028 Device omits ACK (kd=1 at 11th falling edge) -> tx_error one pulse, no done, lines released.
REQ-029 Device never clocks after REQ -> tx_error after exactly TIMEOUT_CYCLES, kc_oe=kd_oe=0.
REQ-030 wr_en pulsed again mid-frame -> ignored, frame unchanged; rst=0 mid-TX -> next cycle outputs 0, state IDLE, no pulses.
REQ-031 INHIBIT length check -> kc_oe high exactly INHIBIT_CYCLES cycles before kd_oe rises.
